// File: rtl/pipe_pkg.sv
// Purpose: shared defaults for the pipeline-stage control slice.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package pipe_pkg;

    // Default depth of the data-register chain.
    localparam int STAGES_DEF = 3;

    // Narrowest counter able to hold 0..stages inclusive.
    function automatic int cntw_for(input int stages);
        return $clog2(stages + 1);
    endfunction

    localparam int CNTW_DEF = cntw_for(STAGES_DEF);

endpackage

// File: rtl/pipe_valid_bit.sv
// Purpose: one stage's valid bit plus its forward-move decision.
// Latency: v updates one clock after load_in; move is combinational from v.
// Backpressure: move only when the downstream path is open and the pipe is not held.
//
// Ports:
//   clock, reset  rising-edge clock, async active-high reset
//   flush         discard this stage's item at the next edge
//   hold          stall or flush: freeze movement this cycle
//   load_in       an item enters this stage at the next edge (already gated)
//   dn_open       downstream can take an item (next stage empty or itself moving)
//   v             this stage holds a valid item
//   move          this stage's item advances; doubles as load for the next stage
module pipe_valid_bit (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic hold,
    input  logic load_in,
    input  logic dn_open,
    output logic v,
    output logic move
);

    assign move = v & dn_open & ~hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v <= 1'b0;
        end else if (flush) begin
            v <= 1'b0;
        end else begin
            // A stage emptied by its own move can be refilled in the same edge.
            v <= load_in | (v & ~move);
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Purpose: load/clear strobe generation and valid tracking for a STAGES-deep register chain.
// Latency: an item accepted in cycle t is presented as out_valid in cycle t+STAGES.
// Backpressure: valid/ready with bubble collapse; stall freezes, flush empties, full pipe passes through.
//
// Ports:
//   clock, reset  rising-edge clock, async active-high reset
//   in_valid      source offers an operand        in_ready  stage 0 accepts this cycle
//   out_valid     last stage holds a result       out_ready consumer takes it this cycle
//   stall         freeze the whole pipe           flush     discard all in-flight items
//   load          per-stage load strobe           clear     per-stage synchronous clear
//   count         registered number of valid stages
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,   // >= 2
    parameter int CNTW   = CNTW_DEF      // 2**CNTW must exceed STAGES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              stall,
    input  logic              flush,
    output logic [STAGES-1:0] load,
    output logic [STAGES-1:0] clear,
    output logic [CNTW-1:0]   count
);

    logic              hold;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] move;
    logic [STAGES-1:0] dn_open;
    logic [STAGES-1:0] ld;
    logic              acc;
    logic              ret;

    assign hold = stall | flush;

    // dn_open[i] is "next stage empty, or next stage moving". Because
    // ~v | (v & x) == ~v | x, the downstream move collapses into a walk over
    // the valid bits alone, which keeps the chain free of combinational
    // feedback between stage instances. Gating by hold happens inside each
    // stage; when hold is set every move is zero anyway.
    always_comb begin
        dn_open             = '0;
        dn_open[STAGES-1]   = out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            dn_open[i] = ~v[i+1] | dn_open[i+1];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipe_valid_bit u_vb (
            .clock   (clock),
            .reset   (reset),
            .flush   (flush),
            .hold    (hold),
            .load_in (ld[i]),
            .dn_open (dn_open[i]),
            .v       (v[i]),
            .move    (move[i])
        );
    end

    // Reset is folded in so the source never sees acceptance while the
    // chain is being cleared.
    assign in_ready = ~reset & ~hold & (~v[0] | move[0]);

    assign ld[0]          = in_valid & in_ready;
    assign ld[STAGES-1:1] = move[STAGES-2:0];

    assign load      = ld;
    assign clear     = {STAGES{reset | flush}};
    assign out_valid = v[STAGES-1];

    assign acc = ld[0];
    assign ret = move[STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CNTW'(acc) - CNTW'(ret);
        end
    end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
module tb_pipe_stage_ctrl;

    localparam int S = 3;
    localparam int W = 2;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic         stall;
    logic         flush;
    logic [S-1:0] load;
    logic [S-1:0] clear;
    logic [W-1:0] count;

    pipe_stage_ctrl #(.STAGES(S), .CNTW(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stall     (stall),
        .flush     (flush),
        .load      (load),
        .clear     (clear),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference: which slots hold an item (slot S-1 faces the consumer).
    bit [S-1:0] slot = '0;

    // Last sampled DUT outputs, for directed checks against fixed values.
    logic         obs_ir;
    logic         obs_ov;
    logic [S-1:0] obs_load;
    logic [S-1:0] obs_clear;
    logic [W-1:0] obs_cnt;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, predict from the item model, sample at negedge, advance.
    task automatic step(input string tag, input logic iv, input logic ordy,
                        input logic st, input logic fl);
        bit [S-1:0] nxt;
        bit [S-1:0] ld_exp;
        bit         hold;
        bit         ir_exp;
        in_valid  = iv;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        hold      = st | fl;
        nxt       = slot;
        ld_exp    = '0;
        // The consumer takes the front item, then each item walks one slot
        // forward if the slot ahead is free, working from the front back.
        if (slot[S-1] && ordy && !hold) nxt[S-1] = 1'b0;
        for (int i = S - 2; i >= 0; i--) begin
            if (slot[i] && !nxt[i+1] && !hold) begin
                nxt[i+1]    = 1'b1;
                nxt[i]      = 1'b0;
                ld_exp[i+1] = 1'b1;
            end
        end
        ir_exp = !hold && !nxt[0];
        if (iv && ir_exp) begin
            nxt[0]    = 1'b1;
            ld_exp[0] = 1'b1;
        end
        @(negedge clock);
        obs_ir    = in_ready;
        obs_ov    = out_valid;
        obs_load  = load;
        obs_clear = clear;
        obs_cnt   = count;
        chk({tag, ".in_ready"},  8'(obs_ir),    8'(ir_exp));
        chk({tag, ".out_valid"}, 8'(obs_ov),    8'(slot[S-1]));
        chk({tag, ".load"},      8'(obs_load),  8'(ld_exp));
        chk({tag, ".clear"},     8'(obs_clear), fl ? 8'(3'b111) : 8'h00);
        chk({tag, ".count"},     8'(obs_cnt),   8'($countones(slot)));
        @(posedge clock);
        slot = fl ? '0 : nxt;
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;

        // Reset state.
        @(negedge clock);
        chk("rst.in_ready",  8'(in_ready),  8'h00);
        chk("rst.out_valid", 8'(out_valid), 8'h00);
        chk("rst.load",      8'(load),      8'h00);
        chk("rst.clear",     8'(clear),     8'(3'b111));
        chk("rst.count",     8'(count),     8'h00);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single item, consumer ready: one strobe per stage, then out_valid.
        step("t2a", 1, 1, 0, 0); chk("t2.load0", 8'(obs_load), 8'(3'b001));
        step("t2b", 0, 1, 0, 0); chk("t2.load1", 8'(obs_load), 8'(3'b010));
        step("t2c", 0, 1, 0, 0); chk("t2.load2", 8'(obs_load), 8'(3'b100));
                                 chk("t2.ov_early", 8'(obs_ov), 8'h00);
        step("t2d", 0, 1, 0, 0); chk("t2.ov", 8'(obs_ov), 8'h01);
        step("t2e", 0, 1, 0, 0); chk("t2.ov_gone", 8'(obs_ov), 8'h00);

        // Fill against a blocked consumer, then pass-through at full rate.
        step("t3a", 1, 0, 0, 0);
        step("t3b", 1, 0, 0, 0);
        step("t3c", 1, 0, 0, 0);
        step("t3d", 1, 0, 0, 0); chk("t3.full_ir", 8'(obs_ir), 8'h00);
                                 chk("t3.full_cnt", 8'(obs_cnt), 8'h03);
        step("t3e", 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step("t3f", 1, 1, 0, 0);
            chk("t3.pass_ir",  8'(obs_ir),  8'h01);
            chk("t3.pass_cnt", 8'(obs_cnt), 8'h03);
        end
        for (int k = 0; k < 4; k++) step("drain", 0, 1, 0, 0);

        // Flush with a concurrent offer.
        step("t4a", 1, 0, 0, 0);
        step("t4b", 1, 0, 0, 0);
        step("t4c", 1, 0, 0, 1); chk("t4.ir",    8'(obs_ir),    8'h00);
                                 chk("t4.clear", 8'(obs_clear), 8'(3'b111));
                                 chk("t4.load",  8'(obs_load),  8'h00);
        step("t4d", 0, 0, 0, 0); chk("t4.cnt",   8'(obs_cnt),   8'h00);
                                 chk("t4.ov",    8'(obs_ov),    8'h00);

        // Stall on a full pipe with the consumer ready.
        step("t5a", 1, 0, 0, 0);
        step("t5b", 1, 0, 0, 0);
        step("t5c", 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step("t5s", 1, 1, 1, 0);
            chk("t5.load", 8'(obs_load), 8'h00);
            chk("t5.cnt",  8'(obs_cnt),  8'h03);
            chk("t5.ov",   8'(obs_ov),   8'h01);
        end
        step("t5r", 0, 1, 0, 0); chk("t5.resume", 8'(obs_load), 8'(3'b110));
        for (int k = 0; k < 4; k++) step("drain", 0, 1, 0, 0);

        // Bubble collapse: items in stages 0 and 2, consumer blocked.
        step("t6a", 1, 0, 0, 0);
        step("t6b", 0, 0, 0, 0);
        step("t6c", 1, 0, 0, 0);
        step("t6d", 0, 0, 0, 0); chk("t6.load", 8'(obs_load), 8'(3'b010));
                                 chk("t6.cnt",  8'(obs_cnt),  8'h02);
        step("t6e", 0, 0, 0, 0); chk("t6.cnt2", 8'(obs_cnt),  8'h02);
        for (int k = 0; k < 4; k++) step("drain", 0, 1, 0, 0);

        // Async reset with two items in flight.
        step("t1a", 1, 0, 0, 0);
        step("t1b", 1, 0, 0, 0);
        step("t1c", 0, 0, 0, 0);
        step("t1d", 0, 0, 0, 0); chk("t1.pre_ov", 8'(obs_ov), 8'h01);
        #2;
        reset = 1'b1;
        #1;
        chk("t1.ov",    8'(out_valid), 8'h00);
        chk("t1.cnt",   8'(count),     8'h00);
        chk("t1.ir",    8'(in_ready),  8'h00);
        chk("t1.load",  8'(load),      8'h00);
        chk("t1.clear", 8'(clear),     8'(3'b111));
        slot = '0;
        @(negedge clock);
        chk("t1.clear_hold", 8'(clear), 8'(3'b111));
        @(posedge clock);
        #1;
        reset = 1'b0;
        step("t1e", 0, 1, 0, 0);

        // Randomized traffic against the item model.
        for (int k = 0; k < 400; k++) begin
            step("rnd",
                 1'($urandom_range(1, 0)),
                 1'($urandom_range(3, 0) != 0),
                 1'($urandom_range(7, 0) == 0),
                 1'($urandom_range(15, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
